// File: rtl/matmul_core_p.sv
`default_nettype none
// ----------------------------------------------------------------------------
// matmul_core_p : striped-row C = A*B worker with a MAC datapath; MATMUL_SATURATE_EN clamps accumulation
// Revision      : 1.0
// ----------------------------------------------------------------------------
module matmul_core_p #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8,
  parameter int ID_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ID_W-1:0]   core_id,
  input  logic [ID_W-1:0]   num_cores,
  input  logic [DIM_W-1:0]  dim_m,
  input  logic [DIM_W-1:0]  dim_n,
  input  logic [DIM_W-1:0]  dim_k,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] c_base,
  output logic [ADDR_W-1:0] dm_addr,
  output logic              dm_rd,
  input  logic [DATA_W-1:0] dm_in,
  output logic              dm_wr,
  output logic [ACC_W-1:0]  dm_wdata,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_A = 3'd1;
  localparam logic [2:0] S_RD_B = 3'd2;
  localparam logic [2:0] S_MAC  = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  // Row index must hold values past M by up to num_cores after a stride.
  localparam int IW = DIM_W + ID_W;
  localparam int PW = IW + DIM_W;
  localparam logic [DIM_W-1:0] DIM_ONE = 1;
  localparam logic [ID_W-1:0]  ID_ONE  = 1;

  logic [2:0]        state, state_next;
  logic [DIM_W-1:0]  m_q, n_q, k_q;
  logic [ID_W-1:0]   nc_q;
  logic [ADDR_W-1:0] a_base_q, b_base_q, c_base_q;
  logic [IW-1:0]     i_q;
  logic [DIM_W-1:0]  j_q;
  logic [DIM_W-1:0]  n_cnt;
  logic [DATA_W-1:0] a_q;
  logic [ACC_W-1:0]  acc;

  logic              degenerate;
  logic              last_n;
  logic              last_j;
  logic [IW-1:0]     i_next;
  logic              rows_done;
  logic [PW-1:0]     off_a, off_b, off_c;
  logic [ADDR_W-1:0] addr_a, addr_b, addr_c;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  acc_next;
`ifdef MATMUL_SATURATE_EN
  logic [ACC_W:0]    sum_wide;
`endif

  always_comb begin
    degenerate = (dim_m == '0) || (dim_n == '0) || (dim_k == '0) ||
                 (IW'(core_id) >= IW'(dim_m));
    last_n     = (n_cnt == (n_q - DIM_ONE));
    last_j     = (j_q == (k_q - DIM_ONE));
    i_next     = last_j ? (i_q + IW'(nc_q)) : i_q;
    rows_done  = (i_next >= IW'(m_q));

    off_a  = PW'(i_q) * PW'(n_q);
    off_b  = PW'(n_cnt) * PW'(k_q);
    off_c  = PW'(i_q) * PW'(k_q);
    addr_a = a_base_q + ADDR_W'(off_a) + ADDR_W'(n_cnt);
    addr_b = b_base_q + ADDR_W'(off_b) + ADDR_W'(j_q);
    addr_c = c_base_q + ADDR_W'(off_c) + ADDR_W'(j_q);

    prod     = (2*DATA_W)'(a_q) * (2*DATA_W)'(dm_in);
    prod_ext = ACC_W'(prod);
`ifdef MATMUL_SATURATE_EN
    sum_wide = {1'b0, acc} + {1'b0, prod_ext};
    acc_next = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
    acc_next = acc + prod_ext;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      m_q      <= '0;
      n_q      <= '0;
      k_q      <= '0;
      nc_q     <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      c_base_q <= '0;
      i_q      <= '0;
      j_q      <= '0;
      n_cnt    <= '0;
      a_q      <= '0;
      acc      <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            m_q      <= dim_m;
            n_q      <= dim_n;
            k_q      <= dim_k;
            nc_q     <= (num_cores == '0) ? ID_ONE : num_cores;
            a_base_q <= a_base;
            b_base_q <= b_base;
            c_base_q <= c_base;
            i_q      <= IW'(core_id);
            j_q      <= '0;
            n_cnt    <= '0;
            acc      <= '0;
          end
        end
        S_RD_B: a_q <= dm_in;
        S_MAC: begin
          acc   <= acc_next;
          n_cnt <= n_cnt + DIM_ONE;
        end
        S_WR: begin
          acc   <= '0;
          n_cnt <= '0;
          j_q   <= last_j ? '0 : (j_q + DIM_ONE);
          i_q   <= i_next;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = S_IDLE;
    case (state)
      S_IDLE: begin
        if (start) state_next = degenerate ? S_DONE : S_RD_A;
        else       state_next = S_IDLE;
      end
      S_RD_A: state_next = S_RD_B;
      S_RD_B: state_next = S_MAC;
      S_MAC:  state_next = last_n ? S_WR : S_RD_A;
      S_WR:   state_next = rows_done ? S_DONE : S_RD_A;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    dm_addr  = '0;
    dm_rd    = 1'b0;
    dm_wr    = 1'b0;
    dm_wdata = '0;
    busy     = (state != S_IDLE);
    done     = 1'b0;
    case (state)
      S_RD_A: begin
        dm_rd   = 1'b1;
        dm_addr = addr_a;
      end
      S_RD_B: begin
        dm_rd   = 1'b1;
        dm_addr = addr_b;
      end
      S_WR: begin
        dm_wr    = 1'b1;
        dm_addr  = addr_c;
        dm_wdata = acc;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_matmul_core_p.sv
`default_nettype none
// Directed self-checking bench for matmul_core_p with a 1-cycle-latency memory model.
module tb_matmul_core_p;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  core_id = '0;
  logic [4:0]  num_cores = '0;
  logic [7:0]  dim_m = '0, dim_n = '0, dim_k = '0;
  logic [15:0] a_base = '0, b_base = '0, c_base = '0;
  logic [15:0] dm_addr;
  logic        dm_rd;
  logic [7:0]  dm_in = '0;
  logic        dm_wr;
  logic [15:0] dm_wdata;
  logic        busy;
  logic        done;

  matmul_core_p dut (
    .clk(clk), .rst(rst), .start(start), .core_id(core_id), .num_cores(num_cores),
    .dim_m(dim_m), .dim_n(dim_n), .dim_k(dim_k),
    .a_base(a_base), .b_base(b_base), .c_base(c_base),
    .dm_addr(dm_addr), .dm_rd(dm_rd), .dm_in(dm_in), .dm_wr(dm_wr),
    .dm_wdata(dm_wdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:1023];
  logic [7:0]  rd_next = '0;
  int          strobe_cnt = 0;
  int          both_cnt = 0;
  int          done_cnt = 0;
  int          wr_addr_q[$];
  int          wr_data_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  // Monitors sample at the falling edge; read data is returned on the next rising edge.
  always @(negedge clk) begin
    if (dm_rd) rd_next = mem[dm_addr[9:0]];
    if (dm_rd || dm_wr) strobe_cnt++;
    if (dm_rd && dm_wr) both_cnt++;
    if (done) done_cnt++;
    if (dm_wr) begin
      wr_addr_q.push_back(int'(dm_addr));
      wr_data_q.push_back(int'(dm_wdata));
    end
  end

  always @(posedge clk) dm_in <= rd_next;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int idx, input int addr, input int data);
    int oa, od;
    oa = (idx < wr_addr_q.size()) ? wr_addr_q[idx] : -1;
    od = (idx < wr_data_q.size()) ? wr_data_q[idx] : -1;
    chk({tag, "_addr"}, oa, addr);
    chk({tag, "_data"}, od, data);
  endtask

  task automatic set_job(input int m, input int n, input int k, input int cid, input int nc,
                         input int ab, input int bb, input int cb);
    dim_m = 8'(m); dim_n = 8'(n); dim_k = 8'(k);
    core_id = 5'(cid); num_cores = 5'(nc);
    a_base = 16'(ab); b_base = 16'(bb); c_base = 16'(cb);
  endtask

  // cyc = rising edges after the accepting edge until done is seen.
  task automatic run_job(output int cyc);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
  endtask

  initial begin
    int cyc, wb, sb, db;
    for (int a = 0; a < 1024; a++) mem[a] = '0;
    mem[16'h010] = 8'd1; mem[16'h011] = 8'd2; mem[16'h012] = 8'd3; mem[16'h013] = 8'd4;
    mem[16'h020] = 8'd5; mem[16'h021] = 8'd6; mem[16'h022] = 8'd7; mem[16'h023] = 8'd8;
    for (int a = 0; a < 5; a++) mem[16'h100 + a] = 8'd1;
    mem[16'h110] = 8'd1;
    mem[16'h200] = 8'd255; mem[16'h201] = 8'd255;
    mem[16'h210] = 8'd255; mem[16'h211] = 8'd255;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd", 32'(dm_rd), 0);
    chk("rst_wr", 32'(dm_wr), 0);
    chk("rst_addr", 32'(dm_addr), 0);
    chk("rst_wdata", 32'(dm_wdata), 0);
    rst = 1'b0;
    @(negedge clk);

    // 2x2 basic job: C = [19 22; 43 50]
    set_job(2, 2, 2, 0, 1, 16'h010, 16'h020, 16'h040);
    wb = wr_addr_q.size();
    run_job(cyc);
    chk("basic_cycles", cyc, 28);
    chk("basic_nwr", wr_addr_q.size() - wb, 4);
    chk_wr("basic_c00", wb + 0, 16'h040, 19);
    chk_wr("basic_c01", wb + 1, 16'h041, 22);
    chk_wr("basic_c10", wb + 2, 16'h042, 43);
    chk_wr("basic_c11", wb + 3, 16'h043, 50);
    chk("basic_busy_after", 32'(busy), 0);
    chk("rd_wr_overlap", both_cnt, 0);

    // Row striding: core 1 of 2, M=5 -> rows 1 and 3
    set_job(5, 1, 1, 1, 2, 16'h100, 16'h110, 16'h120);
    wb = wr_addr_q.size();
    run_job(cyc);
    chk("stride_cycles", cyc, 8);
    chk("stride_nwr", wr_addr_q.size() - wb, 2);
    chk_wr("stride_r1", wb + 0, 16'h121, 1);
    chk_wr("stride_r3", wb + 1, 16'h123, 1);

    // Degenerate jobs: done in the first cycle after acceptance, no memory traffic
    set_job(2, 0, 2, 0, 1, 16'h010, 16'h020, 16'h040);
    sb = strobe_cnt;
    run_job(cyc);
    chk("degen_n0_cycles", cyc, 0);
    chk("degen_n0_strobes", strobe_cnt - sb, 0);
    set_job(2, 2, 2, 3, 1, 16'h010, 16'h020, 16'h040);
    sb = strobe_cnt;
    run_job(cyc);
    chk("degen_cid_cycles", cyc, 0);
    chk("degen_cid_strobes", strobe_cnt - sb, 0);

    // Overflow: 255*255*2 = 130050
    set_job(1, 2, 1, 0, 1, 16'h200, 16'h210, 16'h220);
    wb = wr_addr_q.size();
    run_job(cyc);
    chk("ovf_cycles", cyc, 7);
`ifdef MATMUL_SATURATE_EN
    chk_wr("ovf_c", wb, 16'h220, 65535);
`else
    chk_wr("ovf_c", wb, 16'h220, 64514);
`endif

    // Reset during MAC of the first element
    set_job(2, 2, 2, 0, 1, 16'h010, 16'h020, 16'h040);
    wb = wr_addr_q.size();
    db = done_cnt;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_busy_before", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_rd", 32'(dm_rd), 0);
    chk("midrst_wr", 32'(dm_wr), 0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_nwr", wr_addr_q.size() - wb, 0);
    chk("midrst_ndone", done_cnt - db, 0);
    wb = wr_addr_q.size();
    run_job(cyc);
    chk("rerun_cycles", cyc, 28);
    chk_wr("rerun_c00", wb + 0, 16'h040, 19);
    chk_wr("rerun_c11", wb + 3, 16'h043, 50);

    // start with altered bases while busy must not disturb the running job
    set_job(2, 2, 2, 0, 1, 16'h010, 16'h020, 16'h040);
    wb = wr_addr_q.size();
    db = done_cnt;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    repeat (5) begin
      @(negedge clk);
      cyc++;
    end
    set_job(1, 1, 1, 0, 1, 16'h300, 16'h310, 16'h320);
    start = 1'b1;
    @(negedge clk);
    cyc++;
    start = 1'b0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    chk("busystart_cycles", cyc, 28);
    chk("busystart_nwr", wr_addr_q.size() - wb, 4);
    chk_wr("busystart_c00", wb + 0, 16'h040, 19);
    chk_wr("busystart_c01", wb + 1, 16'h041, 22);
    chk_wr("busystart_c10", wb + 2, 16'h042, 43);
    chk_wr("busystart_c11", wb + 3, 16'h043, 50);
    chk("busystart_ndone", done_cnt - db, 1);
    repeat (5) @(negedge clk);
    chk("busystart_not_queued", 32'(busy), 0);
    chk("rd_wr_overlap_final", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matmul_core_p.md
# matmul_core_p

Parametrised matrix-multiply worker core for the multi-core multiplier array. It computes C = A·B from row-major matrices in data memory. Each instance owns the rows i where i ≡ core_id (mod num_cores) and runs its own sequencer, so several instances can share one matrix job. It replaces the fixed 8-bit microcoded core with a dedicated multiply-accumulate datapath of configurable width and a start/done handshake.

## Interface
Parameters:
- DATA_W, 8, width of A/B elements (unsigned)
- ACC_W, 16, width of accumulator and C elements
- ADDR_W, 16, data-memory address width
- DIM_W, 8, width of each matrix dimension
- ID_W, 5, width of core_id / num_cores

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  job request, sampled only in IDLE
- core_id  in  ID_W  index of this core
- num_cores  in  ID_W  cores sharing the job; 0 treated as 1
- dim_m, dim_n, dim_k  in  DIM_W each  A is M×N, B is N×K, C is M×K
- a_base, b_base, c_base  in  ADDR_W each  matrix base addresses
- dm_addr  out  ADDR_W  memory address
- dm_rd  out  1  read strobe
- dm_in  in  DATA_W  read data, valid the cycle after dm_rd
- dm_wr  out  1  write strobe
- dm_wdata  out  ACC_W  write data (C element)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

## Operation
- Reset values: all outputs 0; FSM in IDLE; accumulator 0.
- States:
  - IDLE
  - RD_A: dm_rd=1, dm_addr = a_base + i·N + n
  - RD_B: dm_rd=1, dm_addr = b_base + n·K + j; capture dm_in as a
  - MAC: capture dm_in as b; acc += a·b; n++
  - WR: dm_wr=1, dm_addr = c_base + i·K + j, dm_wdata = acc; clear acc
  - DONE: done=1
- IDLE + start:
  - core_id, num_cores, dims and bases are latched; later changes on these inputs are ignored until the next IDLE.
  - If M, N or K is 0, or core_id ≥ M, the next state is DONE and no memory access occurs.
  - Otherwise i = core_id, j = 0, n = 0, acc = 0, and the next state is RD_A.
- Sequencing:
  - RD_A → RD_B → MAC.
  - MAC returns to RD_A while n < N−1; otherwise MAC → WR.
  - After WR: j++. When j wraps to 0, i += num_cores.
  - If i ≥ M after that update, WR → DONE; else WR → RD_A with n = 0.
- DONE → IDLE unconditionally.
- start while busy is ignored and is not queued.
- Arithmetic: a·b is an unsigned 2·DATA_W product, zero-extended or truncated to ACC_W. Accumulation wraps mod 2^ACC_W; see Configuration for the saturating option.
- Address arithmetic wraps mod 2^ADDR_W.
- rst asserted in any state:
  - Next cycle the FSM is in IDLE, dm_rd = dm_wr = 0, busy = 0 and acc = 0.
  - No done pulse is produced and any pending C write is lost.
- dm_rd and dm_wr are never high in the same cycle.

## Timing
- Each C element takes 3·N + 1 cycles: N × (RD_A, RD_B, MAC) followed by WR.
- Owned rows: R = ceil((M − core_id) / num_cores) when core_id < M, else 0.
- With start sampled at edge e0, done is high during cycle R·K·(3N+1) after e0. In the degenerate case (R = 0 or any dimension 0) done is high in the cycle immediately after e0.
- busy rises the cycle after start is accepted and falls in the cycle after DONE.
- Memory read latency is fixed at 1 cycle; there is no stall input.

## Configuration
- Macro `MATMUL_SATURATE_EN`:
  - Defined: each accumulation clamps to 2^ACC_W − 1 on unsigned overflow. The clamped value persists for the rest of that element.
  - Undefined: accumulation wraps mod 2^ACC_W.

## Test plan
- Basic 2×2 job:
  - Stimulus: M=N=K=2, core_id=0, num_cores=1, A=[1 2; 3 4], B=[5 6; 7 8].
  - Required: C=[19 22; 43 50] written in order (0,0), (0,1), (1,0), (1,1); done high 28 cycles after start.
- Row striding:
  - Stimulus: M=5, N=K=1, num_cores=2, core_id=1, all elements 1.
  - Required: only rows 1 and 3 written, each with value 1; done high 8 cycles after start.
- Degenerate jobs:
  - Stimulus: N=0; separately core_id=3 with M=2.
  - Required: done high 1 cycle after start; dm_rd and dm_wr never asserted.
- Overflow (ACC_W=16):
  - Stimulus: N=2, A row = [255 255], B column = [255 255].
  - Required: C = 64514 without the macro; C = 65535 with `MATMUL_SATURATE_EN`.
- Reset mid-job:
  - Stimulus: assert rst during MAC of the first element.
  - Required: busy=0, dm_rd=0, dm_wr=0 the next cycle; no write and no done; a subsequent start re-runs the job correctly.
- start while busy:
  - Stimulus: pulse start with different bases mid-job.
  - Required: no effect; the original job completes with unchanged addresses and results.
